uart_tx_serializer: RTL and testbench

UART 8-N-1 transmitter directly downstream of the strip BRAM reader. Accepts one saturated pixel byte per `send` pulse, serializes it LSB-first on `tx` at a fixed baud rate, and returns `busy` so the reader can pace transmission of all eight segmented strips. One byte per frame, no internal queue: back-pressure is entirely through `busy`.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_tx_serializer.sv | 122 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, widths and line constants for uart_tx/uart_rx
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam logic LINE_IDLE = 1'b1;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} uart_state_e;
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte request/busy handshake plus serial line of the transmitter
interface uart_tx_serializer_if;
  import uart_pkg::*;
  logic send;
  logic [DATA_BITS-1:0] transmit_data;
  logic tx;
  logic busy;
  logic tx_done;
  modport master(output send, transmit_data, input tx, busy, tx_done);
  modport slave(input send, transmit_data, output tx, busy, tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: clearable baud counter emitting a one-cycle tick on the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  logic [CNT_W-1:0] cnt_q;
  assign tick = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
  // restart on every bit boundary so bit timing never drifts
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= (clear || tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8-N-1 UART transmitter, busy-paced; define UART_TX_PARITY_EN for 8-E-1
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  uart_tx_serializer_if.slave bus
);
  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic tick;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(state_q == IDLE),
    .tick(tick)
  );
  assign bus.tx = tx_q;
  assign bus.busy = busy_q;
  assign bus.tx_done = done_q;
  // frame state and registered line outputs; reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      idx_q <= '0;
      tx_q <= LINE_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  // next state: tx is loaded one edge ahead so each bit starts exactly on its boundary
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    idx_d = idx_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        busy_d = 1'b0;
        if (bus.send) begin
          sh_d = bus.transmit_data;
          busy_d = 1'b1;
          tx_d = 1'b0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d = even_parity(bus.transmit_data);
`endif
        end
      end
      START:
        if (tick) begin
          tx_d = sh_q[0];
          sh_d = sh_q >> 1;
          idx_d = '0;
          state_d = DATA;
        end
      DATA:
        if (tick) begin
          if (idx_q != 3'(DATA_BITS - 1)) begin
            tx_d = sh_q[0];
            sh_d = sh_q >> 1;
            idx_d = idx_q + 3'd1;
          end else begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d = par_q;
            state_d = PARITY;
`else
            tx_d = LINE_IDLE;
            state_d = STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (tick) begin
          tx_d = LINE_IDLE;
          state_d = STOP;
        end
`endif
      STOP:
        if (tick) begin
          tx_d = LINE_IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
          state_d = IDLE;
        end
      default: begin
        tx_d = LINE_IDLE;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench; frames decoded from tx and compared with queued bytes
module tb_uart_tx_serializer;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * CPB;
  typedef struct {
    logic [7:0] d;
    int e;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int next_free = 0;
  exp_t exp_q[$];
  uart_tx_serializer_if bus ();
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // one clock of stimulus; the model accepts a request only when the line is free
  task automatic cycle(input logic s, input logic [7:0] d);
    int e;
    bus.send = s;
    bus.transmit_data = d;
    e = cyc + 1;
    if (s && reset && e >= next_free) begin
      exp_q.push_back('{d: d, e: e});
      next_free = e + F + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: detects busy rising, decodes one frame from tx, checks against queue head
  initial begin
    exp_t x;
    logic [F-1:0] line;
    logic [NB-1:0] bits;
    logic busy_ok, done_early, aborted, got;
    forever begin
      @(negedge clk);
      if (reset && bus.busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          for (int i = 0; i < F && bus.busy; i++) @(negedge clk);
        end else begin
          x = exp_q.pop_front();
          chk("accept_edge", cyc, x.e);
          bits[0] = 1'b0;
          for (int k = 0; k < 8; k++) bits[1+k] = x.d[k];
`ifdef UART_TX_PARITY_EN
          bits[9] = ^x.d;
`endif
          bits[NB-1] = 1'b1;
          busy_ok = 1'b1;
          done_early = 1'b0;
          aborted = 1'b0;
          for (int i = 0; i < F; i++) begin
            if (i > 0) @(negedge clk);
            if (!reset) begin
              aborted = 1'b1;
              break;
            end
            line[i] = bus.tx;
            busy_ok &= bus.busy;
            done_early |= bus.tx_done;
          end
          if (!aborted) @(negedge clk);
          if (!aborted && reset) begin
            for (int b = 0; b < NB; b++) begin
              got = bits[b];
              for (int k = 0; k < CPB; k++) if (line[b*CPB+k] !== bits[b]) got = line[b*CPB+k];
              chk($sformatf("frame_%02h_bit%0d", x.d, b), got, bits[b]);
            end
            chk("busy_held_frame", busy_ok, 1);
            chk("tx_done_early", done_early, 0);
            chk("busy_end", bus.busy, 0);
            chk("tx_done_end", bus.tx_done, 1);
            chk("tx_idle_end", bus.tx, 1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    bus.send = 1'b0;
    bus.transmit_data = 8'h00;
    @(posedge clk);
    #1;
    repeat (5) begin
      cycle(1'b1, 8'h55);
      chk("rst_tx", bus.tx, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.tx_done, 0);
    end
    bus.send = 1'b0;
    reset = 1'b1;
    repeat (2) cycle(1'b0, 8'h00);
    chk("idle_busy", bus.busy, 0);
    cycle(1'b1, 8'hA5);
    chk("accept_busy", bus.busy, 1);
    chk("accept_tx", bus.tx, 0);
    repeat (F + 5) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h3C);
    repeat (10) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hFF);
    repeat (F + 5) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h00);
    repeat (F + 1) cycle(1'b1, 8'hFF);
    repeat (F + 5) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hC3);
    e = cyc;
    repeat (4 * CPB + 1) cycle(1'b0, 8'h00);
    chk("mid_frame_busy", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_tx", bus.tx, 1);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.tx_done, 0);
    exp_q.delete();
    next_free = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1'b1, 8'h5A);
    repeat (F + 5) cycle(1'b0, 8'h00);
    repeat (400) cycle($urandom_range(0, 9) == 0, 8'($urandom));
    repeat (F + 5) cycle(1'b0, 8'h00);
    chk("queue_drained", exp_q.size(), 0);
    chk("mid_reset_edge_seen", e > 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
